// File: rtl/heap_pq.sv
// heap_pq: binary-heap priority queue held in a register array.
//
// The heap is a 0-based implicit tree (parent (i-1)/2, children 2i+1/2i+2).
// One command is accepted while idle; the heap is then restored by a
// sift-up or sift-down walk doing one compare/swap per clock.
//
// Parameters:
//   DATA_W   key width
//   DEPTH    number of entries (power of two, >= 4)
//   MIN_HEAP 0 = largest key at root, 1 = smallest key at root
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op, cmd_data      0 PUSH, 1 POP, 2 REPLACE, 3 CLEAR; key operand
//   rsp_valid/ok/data     one-cycle response pulse after each accepted command
//   top_valid, top_data   current root, valid when idle and non-empty
//   count, full, empty    occupancy
//
// Optional build macro HEAP_PQ_STATS_EN adds:
//   stat_peak  highest count since reset or CLEAR
//   stat_err   saturating count of rsp_ok=0 responses
module heap_pq #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int MIN_HEAP = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  output logic                     rsp_ok,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     top_valid,
  output logic [DATA_W-1:0]        top_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef HEAP_PQ_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   stat_peak,
  output logic [15:0]              stat_err
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int LW = CW + 1;

  localparam logic [1:0] OP_PUSH    = 2'd0;
  localparam logic [1:0] OP_POP     = 2'd1;
  localparam logic [1:0] OP_REPLACE = 2'd2;
  localparam logic [1:0] OP_CLEAR   = 2'd3;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [CW-1:0]       r_count;
  logic [IW-1:0]       r_idx;
  logic                r_rsp_valid, r_rsp_ok;
  logic [DATA_W-1:0]   r_rsp_data;

  // Strict ordering: equal keys are never "better", so they never swap.
  function automatic logic f_better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (MIN_HEAP != 0) return a < b;
    else               return a > b;
  endfunction

  logic          w_acc, w_full, w_empty;
  logic          w_do_push, w_do_pop, w_do_repl, w_do_clear, w_fail;
  logic [IW-1:0] w_par, w_last, w_lidx, w_ridx, w_c;
  logic [LW-1:0] w_l, w_r;
  logic          w_has_l, w_has_r, w_pick_r, w_up_swap, w_dn_swap, w_c_leaf;

  assign w_acc   = cmd_valid && (r_state == IDLE);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // REPLACE on an empty heap degenerates to PUSH.
  assign w_do_push  = w_acc && (((cmd_op == OP_PUSH) && !w_full) || ((cmd_op == OP_REPLACE) && w_empty));
  assign w_do_pop   = w_acc && (cmd_op == OP_POP) && !w_empty;
  assign w_do_repl  = w_acc && (cmd_op == OP_REPLACE) && !w_empty;
  assign w_do_clear = w_acc && (cmd_op == OP_CLEAR);
  assign w_fail     = w_acc && (((cmd_op == OP_PUSH) && w_full) || ((cmd_op == OP_POP) && w_empty));

  // Index of the last entry; count==DEPTH wraps to 0 and the subtraction
  // brings it back to DEPTH-1.
  assign w_last = r_count[IW-1:0] - IW'(1);

  // Sift-up: compare with parent.
  assign w_par     = (r_idx - IW'(1)) >> 1;
  assign w_up_swap = (r_idx != '0) && f_better(r_mem[r_idx], r_mem[w_par]);

  // Sift-down: child indices computed one bit wider so they can be compared
  // against count without overflow.
  assign w_l      = {1'b0, r_idx, 1'b1};
  assign w_r      = w_l + LW'(1);
  assign w_has_l  = w_l < {1'b0, r_count};
  assign w_has_r  = w_r < {1'b0, r_count};
  assign w_lidx   = w_l[IW-1:0];
  assign w_ridx   = w_r[IW-1:0];
  assign w_pick_r = w_has_r && f_better(r_mem[w_ridx], r_mem[w_lidx]);
  assign w_c      = w_pick_r ? w_ridx : w_lidx;
  assign w_dn_swap = w_has_l && f_better(r_mem[w_c], r_mem[r_idx]);
  // Leaving as soon as the swapped-into slot is a leaf keeps the walk
  // within log2(DEPTH) cycles.
  assign w_c_leaf = {1'b0, w_c, 1'b1} >= {1'b0, r_count};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_do_push)                         w_next = SIFT_UP;
        else if (w_do_repl)                    w_next = SIFT_DOWN;
        else if (w_do_pop && (r_count > CW'(2))) w_next = SIFT_DOWN;
      end
      // Finishing on the swap that lands at the root saves a cycle.
      SIFT_UP:   if (!(w_up_swap && (w_par != '0))) w_next = IDLE;
      SIFT_DOWN: if (!(w_dn_swap && !w_c_leaf))     w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_rsp_data  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_rsp_valid <= w_acc;
      r_rsp_ok    <= 1'b0;
      r_rsp_data  <= '0;
      if (w_do_push) begin
        r_mem[r_count[IW-1:0]] <= cmd_data;
        r_count    <= r_count + CW'(1);
        r_idx      <= r_count[IW-1:0];
        r_rsp_ok   <= 1'b1;
        r_rsp_data <= cmd_data;
      end else if (w_do_pop) begin
        r_mem[0]   <= r_mem[w_last];
        r_count    <= r_count - CW'(1);
        r_idx      <= '0;
        r_rsp_ok   <= 1'b1;
        r_rsp_data <= r_mem[0];
      end else if (w_do_repl) begin
        r_mem[0]   <= cmd_data;
        r_idx      <= '0;
        r_rsp_ok   <= 1'b1;
        r_rsp_data <= r_mem[0];
      end else if (w_do_clear) begin
        r_count    <= '0;
        r_rsp_ok   <= 1'b1;
      end else if ((r_state == SIFT_UP) && w_up_swap) begin
        r_mem[r_idx] <= r_mem[w_par];
        r_mem[w_par] <= r_mem[r_idx];
        r_idx        <= w_par;
      end else if ((r_state == SIFT_DOWN) && w_dn_swap) begin
        r_mem[r_idx] <= r_mem[w_c];
        r_mem[w_c]   <= r_mem[r_idx];
        r_idx        <= w_c;
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_data  = r_rsp_data;
  assign top_valid = (r_state == IDLE) && !w_empty;
  assign top_data  = r_mem[0];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

`ifdef HEAP_PQ_STATS_EN
  logic [CW-1:0] r_peak;
  logic [15:0]   r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak <= '0;
      r_err  <= '0;
    end else begin
      if (w_do_clear)           r_peak <= '0;
      else if (r_count > r_peak) r_peak <= r_count;
      if (w_fail && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
    end
  end

  assign stat_peak = r_peak;
  assign stat_err  = r_err;
`endif

endmodule
